sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Sequencing and handshake controller for the 512x36 block-RAM synchronous FIFO macro. It generates the macro's multi-cycle reset and recovery sequence and gates the macro's write and read enables against FULL and EMPTY. It hides the macro's one-cycle read latency behind a 2-entry output buffer, so downstream logic sees a registered valid/ready stream at full throughput. It sits between producer/consumer logic and the macro instance, and it is the only block allowed to drive the macro's RST, WREN and RDEN pins.

## Interface
- DATA_WIDTH, 32: payload width; must be ≤ 36.
- RST_HOLD_CYCLES, 5: cycles `mac_rst_o` is held high per reset/flush; ≥ 1.
- RST_RECOVER_CYCLES, 4: idle cycles after `mac_rst_o` falls, before any WREN/RDEN; ≥ 1.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all contents; honoured only in RUN
- in_data_i  in  DATA_WIDTH  write payload
- in_valid_i  in  1  producer has data
- in_ready_o  out  1  controller accepts data
- out_data_o  out  DATA_WIDTH  head of queue
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  consumer takes head
- mac_rst_o  out  1  macro RST
- mac_wren_o  out  1  macro WREN
- mac_di_o  out  DATA_WIDTH  macro DI (= in_data_i)
- mac_rden_o  out  1  macro RDEN
- mac_do_i  in  DATA_WIDTH  macro DO; valid the cycle after RDEN
- mac_empty_i, mac_full_i  in  1 each  macro EMPTY/FULL; valid for the current cycle's RDEN/WREN
- mac_rderr_i, mac_wrerr_i  in  1 each  macro RDERR/WRERR
- busy_o  out  1  reset/recovery in progress
- usage_o  out  10  words held: macro + in-flight read + output buffer (0..514)
- err_o  out  1  sticky: macro error seen

## Operation

**States.** HOLD, RECOVER, RUN.
- HOLD: `mac_rst_o` = 1. After RST_HOLD_CYCLES cycles, go to RECOVER.
- RECOVER: `mac_rst_o` = 0, no enables. After RST_RECOVER_CYCLES cycles, go to RUN.
- RUN: normal operation.
- `rst_i` forces HOLD with the cycle counter at 0, every cycle it is high.
- `flush_i` high in RUN → HOLD next cycle.
- `flush_i` outside RUN: ignored.

**Busy.** `busy_o` = (state ≠ RUN).

**Write side.**
- `in_ready_o` = RUN & !mac_full_i & !flush_i.
- `mac_wren_o` = in_valid_i & in_ready_o.

**Read side.** Let `ob_cnt` (0..2) be output-buffer occupancy, `infl` (0/1) a registered in-flight read, and `pop` = out_valid_o & out_ready_i.
- `mac_rden_o` = RUN & !flush_i & !mac_empty_i & (ob_cnt + infl − pop < 2).
- `infl` is set on the cycle after RDEN. While `infl` = 1, `mac_do_i` is written into the buffer tail at the clock edge.
- The output buffer is a FIFO: `out_data_o` is always the oldest entry, and `out_valid_o` = (ob_cnt ≠ 0).
- A capture and a pop in the same cycle are both applied; `ob_cnt` is unchanged.
- Ordering is strict FIFO. The buffer can never overflow, by construction.

**Flush / reset.**
- On entry to HOLD, clear `ob_cnt`, `infl` and usage.
- A read in flight at flush time is discarded.
- A pop on the flush cycle itself is honoured.

**Usage counter.** `usage_o` += `mac_wren_o`, −= `pop`, both in the same cycle allowed. It is 10-bit and never wraps in legal operation.

**Error flag.** `err_o` is set when `mac_rderr_i | mac_wrerr_i` in RUN. It is cleared only by `rst_i`, not by flush.

**Reset values.** state = HOLD, `mac_rst_o` = 1, `busy_o` = 1, `usage_o` = 0, `err_o` = 0. All other outputs are 0; `out_data_o` is 0.

## Timing
- Sequencing, with cycle 0 = first cycle with `rst_i` low (defaults):
  - `mac_rst_o` high in cycles 0–4.
  - RECOVER in cycles 5–8.
  - RUN, `busy_o` low and `in_ready_o` possible from cycle 9.
- Flush asserted in cycle F:
  - `in_ready_o` low in cycle F.
  - HOLD during F+1..F+5; RUN again at F+10.
- Latency: RDEN in cycle c → `out_valid_o` high in cycle c+2. Empty macro, write accepted in cycle T, EMPTY low in T+1 → `out_valid_o` in T+3.
- Throughput: one push and one pop per cycle sustained. The 2-entry buffer absorbs the in-flight read while `out_ready_i` is low.
- `out_valid_o` and `out_data_o` are registered. `in_ready_o`, `mac_wren_o` and `mac_rden_o` are combinational from registered state and macro flags.

## Test plan
The bench models the macro as a 512-entry FIFO with DO valid one cycle after RDEN and EMPTY/FULL derived from its count.

- Reset sequencing: release `rst_i` at cycle 0 → `mac_rst_o` = 1 in cycles 0–4, `busy_o` falls at cycle 9, no WREN/RDEN before cycle 9.
- Single word: push 0xA5A5_0001 at T with `out_ready_i` = 1 → `out_valid_o` in T+3 with that data, `usage_o` 1→0 after the pop.
- Streaming: 1000 pushes with random `out_ready_i` (50%) → output in order, no loss or duplication, `usage_o` tracks model, `err_o` = 0.
- Full: `out_ready_i` = 0, push 600 words → `in_ready_o` falls after 514 accepted (512 macro + 2 buffer), `usage_o` = 514, no WREN while FULL.
- Flush: 10 words queued, `flush_i` pulsed with an in-flight read → `usage_o` = 0 and `out_valid_o` = 0 next cycle, `mac_rst_o` high 5 cycles, RUN 10 cycles after flush, no stale word emitted afterwards.
- Errors: force `mac_wrerr_i` one cycle → `err_o` = 1 and stays 1 through a flush; cleared only by `rst_i`.

Source files
------------

// File: rtl/sram_fifo_ctrl_if.sv
// rtl/sram_fifo_ctrl_if.sv - stream and FIFO macro signal bundle for sram_fifo_ctrl
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  mac_rst_o;
  logic                  mac_wren_o;
  logic [DATA_WIDTH-1:0] mac_di_o;
  logic                  mac_rden_o;
  logic [DATA_WIDTH-1:0] mac_do_i;
  logic                  mac_empty_i;
  logic                  mac_full_i;
  logic                  mac_rderr_i;
  logic                  mac_wrerr_i;

  // Controller side
  modport master (
    input  in_data_i, in_valid_i, out_ready_i,
    input  mac_do_i, mac_empty_i, mac_full_i, mac_rderr_i, mac_wrerr_i,
    output in_ready_o, out_data_o, out_valid_o,
    output mac_rst_o, mac_wren_o, mac_di_o, mac_rden_o
  );

  // Producer/consumer and macro side
  modport slave (
    output in_data_i, in_valid_i, out_ready_i,
    output mac_do_i, mac_empty_i, mac_full_i, mac_rderr_i, mac_wrerr_i,
    input  in_ready_o, out_data_o, out_valid_o,
    input  mac_rst_o, mac_wren_o, mac_di_o, mac_rden_o
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - reset sequencing, enable gating and read-latency buffer for the 512x36 FIFO macro
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH         = 32,
  parameter int RST_HOLD_CYCLES    = 5,
  parameter int RST_RECOVER_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  sram_fifo_ctrl_if.master      bus,
  output logic                  busy_o,
  output logic [9:0]            usage_o,
  output logic                  err_o
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {ST_HOLD, ST_RECOVER, ST_RUN} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  mac_rst_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] ob0;
  logic [DATA_WIDTH-1:0] ob1;
  logic [1:0]            ob_cnt;
  logic [1:0]            ob_cnt_nxt;
  logic                  ob_valid;
  logic                  infl;
  logic [9:0]            usage_q;
  logic                  err_q;

  logic                  run;
  logic                  in_ready;
  logic                  wren;
  logic                  rden;
  logic                  pop;

  assign run      = (state == ST_RUN);
  assign in_ready = run & ~bus.mac_full_i & ~flush_i;
  assign wren     = bus.in_valid_i & in_ready;
  assign pop      = ob_valid & bus.out_ready_i;
  // Issue a read only if the word it returns is guaranteed a buffer slot.
  assign rden     = run & ~flush_i & ~bus.mac_empty_i &
                    ((3'(ob_cnt) + 3'(infl)) < (3'd2 + 3'(pop)));

  assign bus.in_ready_o  = in_ready;
  assign bus.mac_wren_o  = wren;
  assign bus.mac_rden_o  = rden;
  assign bus.mac_di_o    = bus.in_data_i;
  assign bus.mac_rst_o   = mac_rst_q;
  assign bus.out_data_o  = ob0;
  assign bus.out_valid_o = ob_valid;
  assign busy_o          = busy_q;
  assign usage_o         = usage_q;
  assign err_o           = err_q;

  // Output buffer occupancy after this cycle's capture and pop
  always_comb begin
    ob_cnt_nxt = ob_cnt + 2'(infl) - 2'(pop);
  end

  // Reset/recovery sequencer with registered macro reset and busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      mac_rst_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
            state     <= ST_RECOVER;
            cnt       <= '0;
            mac_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (cnt == CNT_W'(RST_RECOVER_CYCLES - 1)) begin
            state  <= ST_RUN;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            mac_rst_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state     <= ST_HOLD;
          cnt       <= '0;
          mac_rst_q <= 1'b1;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // In-flight tracking, 2-entry output buffer and usage count; flush drops everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ob0      <= '0;
      ob1      <= '0;
      ob_cnt   <= '0;
      ob_valid <= 1'b0;
      infl     <= 1'b0;
      usage_q  <= '0;
    end else if (run && flush_i) begin
      ob_cnt   <= '0;
      ob_valid <= 1'b0;
      infl     <= 1'b0;
      usage_q  <= '0;
    end else begin
      infl     <= rden;
      usage_q  <= usage_q + 10'(wren) - 10'(pop);
      ob_cnt   <= ob_cnt_nxt;
      ob_valid <= (ob_cnt_nxt != 2'd0);
      case ({infl, pop})
        2'b10: begin
          if (ob_cnt == 2'd0) ob0 <= bus.mac_do_i;
          else                ob1 <= bus.mac_do_i;
        end
        2'b01: ob0 <= ob1;
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= bus.mac_do_i;
          end else begin
            ob0 <= ob1;
            ob1 <= bus.mac_do_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky macro error flag, survives flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (run && (bus.mac_rderr_i || bus.mac_wrerr_i)) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - directed self-checking bench for sram_fifo_ctrl
module tb_sram_fifo_ctrl;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       busy;
  logic [9:0] usage;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  sram_fifo_ctrl dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (bus),
    .busy_o (busy),
    .usage_o(usage),
    .err_o  (err)
  );

  // Macro model: 512-deep FIFO, DO registered one cycle after RDEN
  logic [DW-1:0] mem [0:511];
  int wp = 0;
  int rp = 0;
  int mcnt = 0;

  assign bus.mac_empty_i = (mcnt == 0);
  assign bus.mac_full_i  = (mcnt == 512);

  initial bus.mac_do_i = '0;

  always @(posedge clk) begin
    if (bus.mac_rst_o === 1'b1) begin
      wp   <= 0;
      rp   <= 0;
      mcnt <= 0;
    end else begin
      if (bus.mac_wren_o === 1'b1) begin
        mem[wp] <= bus.mac_di_o;
        wp      <= (wp + 1) % 512;
      end
      if (bus.mac_rden_o === 1'b1) begin
        bus.mac_do_i <= mem[rp];
        rp           <= (rp + 1) % 512;
      end
      mcnt <= mcnt + ((bus.mac_wren_o === 1'b1) ? 1 : 0) - ((bus.mac_rden_o === 1'b1) ? 1 : 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    #1;
    n_cmp++; if (bus.mac_rst_o !== 1'b1) begin n_bad++; $display("FAIL reset_mac_rst got %b want 1", bus.mac_rst_o); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", busy); end
    n_cmp++; if (usage !== 10'd0) begin n_bad++; $display("FAIL reset_usage got %0d want 0", usage); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.out_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", bus.out_data_o); end
    n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready_o); end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      rst = 1'b0;
      bus.in_valid_i = (c < 9);
      bus.in_data_i  = 32'hDEAD_0000 + c;
      #1;
      n_cmp++; if (bus.mac_rst_o !== (c < 5)) begin n_bad++; $display("FAIL seq_mac_rst cycle %0d got %b want %b", c, bus.mac_rst_o, (c < 5)); end
      n_cmp++; if (busy !== (c < 9)) begin n_bad++; $display("FAIL seq_busy cycle %0d got %b want %b", c, busy, (c < 9)); end
      n_cmp++; if (bus.in_ready_o !== (c >= 9)) begin n_bad++; $display("FAIL seq_in_ready cycle %0d got %b want %b", c, bus.in_ready_o, (c >= 9)); end
      if (c < 9) begin
        n_cmp++; if (bus.mac_wren_o !== 1'b0 || bus.mac_rden_o !== 1'b0) begin n_bad++; $display("FAIL seq_enables cycle %0d got wren %b rden %b want 0 0", c, bus.mac_wren_o, bus.mac_rden_o); end
      end
    end
  endtask

  task automatic test_single();
    step();
    bus.in_data_i   = 32'hA5A5_0001;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.mac_wren_o !== 1'b1) begin n_bad++; $display("FAIL single_wren got %b want 1", bus.mac_wren_o); end
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.in_valid_i = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid_o !== (k == 3)) begin n_bad++; $display("FAIL single_valid T+%0d got %b want %b", k, bus.out_valid_o, (k == 3)); end
      if (k == 3) begin
        n_cmp++; if (bus.out_data_o !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_data got %h want a5a50001", bus.out_data_o); end
      end
      if (k == 1) begin
        n_cmp++; if (usage !== 10'd1) begin n_bad++; $display("FAIL single_usage_1 got %0d want 1", usage); end
      end
      if (k == 4) begin
        n_cmp++; if (usage !== 10'd0) begin n_bad++; $display("FAIL single_usage_0 got %0d want 0", usage); end
      end
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_q[$];
    int pushed = 0;
    int mu = 0;
    int cyc = 0;
    logic w, p;
    while (!(pushed == 1000 && exp_q.size() == 0) && cyc < 20000) begin
      step();
      bus.in_valid_i  = (pushed < 1000);
      bus.in_data_i   = 32'h1000_0000 + pushed;
      bus.out_ready_i = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      w = bus.mac_wren_o;
      p = bus.out_valid_o & bus.out_ready_i;
      n_cmp++; if (usage !== 10'(mu)) begin n_bad++; $display("FAIL stream_usage cycle %0d got %0d want %0d", cyc, usage, mu); end
      if (p) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra got %h want nothing", bus.out_data_o);
        end else begin
          if (bus.out_data_o !== exp_q[0]) begin n_bad++; $display("FAIL stream_data got %h want %h", bus.out_data_o, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (w) begin
        exp_q.push_back(bus.in_data_i);
        pushed++;
      end
      mu = mu + int'(w) - int'(p);
    end
    n_cmp++; if (cyc >= 20000) begin n_bad++; $display("FAIL stream_timeout pushed %0d pending %0d want 1000 0", pushed, exp_q.size()); end
    step();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    #1;
    n_cmp++; if (usage !== 10'd0) begin n_bad++; $display("FAIL stream_end_usage got %0d want 0", usage); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL stream_end_valid got %b want 0", bus.out_valid_o); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL stream_err got %b want 0", err); end
  endtask

  task automatic test_full();
    int acc = 0;
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      bus.in_valid_i  = 1'b1;
      bus.in_data_i   = 32'h2000_0000 + acc;
      bus.out_ready_i = 1'b0;
      #1;
      n_cmp++; if (bus.mac_full_i && bus.mac_wren_o) begin n_bad++; $display("FAIL full_wren_while_full cycle %0d got 1 want 0", i); end
      if (bus.mac_wren_o) acc++;
    end
    n_cmp++; if (acc != 514) begin n_bad++; $display("FAIL full_accepted got %0d want 514", acc); end
    n_cmp++; if (usage !== 10'd514) begin n_bad++; $display("FAIL full_usage got %0d want 514", usage); end
    n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b want 0", bus.in_ready_o); end
    n_cmp++; if (bus.out_data_o !== 32'h2000_0000) begin n_bad++; $display("FAIL full_head got %h want 20000000", bus.out_data_o); end
    while (got < 514 && cyc < 2000) begin
      step();
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      #1;
      cyc++;
      if (bus.out_valid_o) begin
        n_cmp++; if (bus.out_data_o !== 32'h2000_0000 + got) begin n_bad++; $display("FAIL full_drain_data got %h want %h", bus.out_data_o, 32'h2000_0000 + got); end
        got++;
      end
    end
    n_cmp++; if (got != 514) begin n_bad++; $display("FAIL full_drain_count got %0d want 514", got); end
    step();
    #1;
    n_cmp++; if (usage !== 10'd0) begin n_bad++; $display("FAIL full_drain_usage got %0d want 0", usage); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) begin
      step();
      bus.in_valid_i  = 1'b1;
      bus.in_data_i   = 32'h3000_0000 + i;
      bus.out_ready_i = 1'b0;
    end
    repeat (4) begin
      step();
      bus.in_valid_i = 1'b0;
    end
    #1;
    n_cmp++; if (usage !== 10'd10) begin n_bad++; $display("FAIL flush_pre_usage got %0d want 10", usage); end
    step();
    bus.out_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.out_data_o !== 32'h3000_0000 || bus.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL flush_pre_pop got %h/%b want 30000000/1", bus.out_data_o, bus.out_valid_o); end
    n_cmp++; if (bus.mac_rden_o !== 1'b1) begin n_bad++; $display("FAIL flush_pre_rden got %b want 1", bus.mac_rden_o); end
    step();
    bus.out_ready_i = 1'b0;
    flush = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready_o); end
    n_cmp++; if (bus.mac_rden_o !== 1'b0) begin n_bad++; $display("FAIL flush_rden got %b want 0", bus.mac_rden_o); end
    for (int j = 1; j <= 15; j++) begin
      step();
      flush = 1'b0;
      bus.out_ready_i = 1'b1;
      #1;
      if (j == 1) begin
        n_cmp++; if (usage !== 10'd0) begin n_bad++; $display("FAIL flush_usage got %0d want 0", usage); end
      end
      if (j <= 10) begin
        n_cmp++; if (bus.mac_rst_o !== (j <= 5)) begin n_bad++; $display("FAIL flush_mac_rst F+%0d got %b want %b", j, bus.mac_rst_o, (j <= 5)); end
        n_cmp++; if (busy !== (j < 10)) begin n_bad++; $display("FAIL flush_busy F+%0d got %b want %b", j, busy, (j < 10)); end
      end
      n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_stale F+%0d got %b want 0", j, bus.out_valid_o); end
    end
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_err();
    step();
    bus.mac_wrerr_i = 1'b1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_before got %b want 0", err); end
    step();
    bus.mac_wrerr_i = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err); end
    step();
    flush = 1'b1;
    #1;
    repeat (12) begin
      step();
      flush = 1'b0;
    end
    #1;
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL err_after_flush got err %b busy %b want 1 0", err, busy); end
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_before_rst_edge got %b want 1", err); end
    step();
    rst = 1'b0;
    bus.mac_rderr_i = 1'b1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", err); end
    repeat (3) step();
    bus.mac_rderr_i = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_ignored_in_hold got %b want 0", err); end
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    bus.in_data_i   = '0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.mac_rderr_i = 1'b0;
    bus.mac_wrerr_i = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_full();
    test_flush();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
